// File: rtl/npu_align_pkg.sv
// Shared types and sizing helpers for the group alignment front-end.
package npu_align_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } align_state_e;

    // Counter width able to index GROUP elements; never narrower than one bit.
    function automatic int cnt_width(input int group);
        return (group <= 2) ? 1 : $clog2(group);
    endfunction

    // Largest right shift the downstream shifter can express.
    function automatic int shift_limit(input int shift_width);
        return (1 << shift_width) - 1;
    endfunction

endpackage

// File: rtl/align_shift_calc.sv
// Combinational shift calculation: d = max_exp - elem_exp, saturated to the shifter range.
// ALIGN_FLUSH_EN: out-of-range elements are flushed (flush=1, shift=0) instead of saturated.
module align_shift_calc
    import npu_align_pkg::*;
#(
    parameter int EXP_WIDTH   = 5,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic [EXP_WIDTH-1:0]   max_exp,
    input  logic [EXP_WIDTH-1:0]   elem_exp,
    output logic [SHIFT_WIDTH-1:0] shift,
    output logic                   flush
);

    localparam int SHIFT_LIMIT = shift_limit(SHIFT_WIDTH);

    logic [EXP_WIDTH-1:0] diff;

    function automatic logic over_limit(input logic [EXP_WIDTH-1:0] d);
        return int'(d) > SHIFT_LIMIT;
    endfunction

    function automatic logic [SHIFT_WIDTH-1:0] sat_shift(input logic [EXP_WIDTH-1:0] d);
        if (over_limit(d)) begin
            return SHIFT_WIDTH'(SHIFT_LIMIT);
        end
        return SHIFT_WIDTH'(d);
    endfunction

    // max_exp is the group maximum, so the difference never wraps.
    assign diff = max_exp - elem_exp;

`ifdef ALIGN_FLUSH_EN
    assign flush = over_limit(diff);
    assign shift = flush ? '0 : sat_shift(diff);
`else
    assign flush = 1'b0;
    assign shift = sat_shift(diff);
`endif

endmodule

// File: rtl/group_align_ctrl.sv
// Group alignment front-end: buffers GROUP (mantissa, exponent) pairs, finds the max exponent,
// then replays each element with its right-shift amount. ALIGN_FLUSH_EN selects flush vs saturate.
module group_align_ctrl
    import npu_align_pkg::*;
#(
    parameter int MANT_WIDTH  = 10,
    parameter int EXP_WIDTH   = 5,
    parameter int SHIFT_WIDTH = 3,
    parameter int GROUP       = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic signed [MANT_WIDTH-1:0] i_mant,
    input  logic [EXP_WIDTH-1:0]         i_exp,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic signed [MANT_WIDTH-1:0] o_mant,
    output logic [SHIFT_WIDTH-1:0]       o_shift,
    output logic [EXP_WIDTH-1:0]         o_max_exp,
    output logic                         o_last
);

    localparam int               CNT_W    = cnt_width(GROUP);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(GROUP - 1);

    align_state_e         state;
    logic [CNT_W-1:0]     wr_cnt;
    logic [CNT_W-1:0]     rd_cnt;
    logic [EXP_WIDTH-1:0] max_exp;
    logic [EXP_WIDTH-1:0] next_max;
    logic                 accept;
    logic                 xfer;

    logic signed [MANT_WIDTH-1:0] mant_buf [GROUP];
    logic [EXP_WIDTH-1:0]         exp_buf  [GROUP];

    logic [SHIFT_WIDTH-1:0] calc_shift;
    logic                   calc_flush;

    assign o_ready = (state == FILL);
    assign o_valid = (state == DRAIN);
    assign accept  = i_valid && o_ready;
    assign xfer    = o_valid && i_ready;

    // The first element of a group loads the running max instead of comparing with stale data.
    assign next_max = ((wr_cnt == '0) || (i_exp > max_exp)) ? i_exp : max_exp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            max_exp   <= '0;
            o_max_exp <= '0;
        end else if (i_clear) begin
            state  <= FILL;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        max_exp <= next_max;
                        if (wr_cnt == LAST_IDX) begin
                            wr_cnt    <= '0;
                            o_max_exp <= next_max;
                            state     <= DRAIN;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (rd_cnt == LAST_IDX) begin
                            rd_cnt <= '0;
                            state  <= FILL;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Element storage carries no reset; the FSM never exposes an unwritten slot.
    always_ff @(posedge i_clk) begin
        if (accept && !i_clear) begin
            mant_buf[wr_cnt] <= i_mant;
            exp_buf[wr_cnt]  <= i_exp;
        end
    end

    align_shift_calc #(
        .EXP_WIDTH  (EXP_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_shift_calc (
        .max_exp (o_max_exp),
        .elem_exp(exp_buf[rd_cnt]),
        .shift   (calc_shift),
        .flush   (calc_flush)
    );

    // Outputs are decoded from registered state only, so they read as zero outside DRAIN.
    assign o_mant  = (o_valid && !calc_flush) ? mant_buf[rd_cnt] : '0;
    assign o_shift = o_valid ? calc_shift : '0;
    assign o_last  = o_valid && (rd_cnt == LAST_IDX);

endmodule

// File: tb/tb_group_align_ctrl.sv
// Self-checking bench for group_align_ctrl: table vectors, corner sequences and randomized traffic.
module tb_group_align_ctrl;

    localparam int MW    = 10;
    localparam int EW    = 5;
    localparam int SW    = 3;
    localparam int GROUP = 8;
    localparam int LIMIT = (1 << SW) - 1;

    logic                 clk;
    logic                 rst_n;
    logic                 i_clear;
    logic                 i_valid;
    logic                 o_ready;
    logic signed [MW-1:0] i_mant;
    logic [EW-1:0]        i_exp;
    logic                 o_valid;
    logic                 i_ready;
    logic signed [MW-1:0] o_mant;
    logic [SW-1:0]        o_shift;
    logic [EW-1:0]        o_max_exp;
    logic                 o_last;

    group_align_ctrl #(
        .MANT_WIDTH (MW),
        .EXP_WIDTH  (EW),
        .SHIFT_WIDTH(SW),
        .GROUP      (GROUP)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_clear  (i_clear),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_mant   (i_mant),
        .i_exp    (i_exp),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_mant   (o_mant),
        .o_shift  (o_shift),
        .o_max_exp(o_max_exp),
        .o_last   (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int mant;
        int shift;
        int last;
        int maxe;
    } ev_t;

    typedef struct {
        int mant;
        int exp;
        int shift;
        int flushed;
        int maxe;
    } vec_t;

    int   n_tests;
    int   n_fail;
    int   grp_m[$];
    int   grp_e[$];
    ev_t  expq[$];
    vec_t tbl[16];

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: a completed group becomes GROUP expected outputs computed from the element list.
    function automatic void build_group();
        int  mx;
        ev_t ev;
        mx = 0;
        foreach (grp_e[i]) if (grp_e[i] > mx) mx = grp_e[i];
        foreach (grp_e[i]) begin
            int d;
            d       = mx - grp_e[i];
            ev.maxe = mx;
            ev.last = (i == GROUP - 1) ? 1 : 0;
            if (d > LIMIT) begin
`ifdef ALIGN_FLUSH_EN
                ev.mant  = 0;
                ev.shift = 0;
`else
                ev.mant  = grp_m[i];
                ev.shift = LIMIT;
`endif
            end else begin
                ev.mant  = grp_m[i];
                ev.shift = d;
            end
            expq.push_back(ev);
        end
        grp_m.delete();
        grp_e.delete();
    endfunction

    // Called at posedge+1: drive inputs, check outputs against the model, advance one edge.
    task automatic step(input bit v, input logic signed [MW-1:0] m, input logic [EW-1:0] e,
                        input bit rdy, input bit clr);
        bit acc;
        bit xf;
        i_valid = v;
        i_mant  = m;
        i_exp   = e;
        i_ready = rdy;
        i_clear = clr;
        check("o_ready", int'(o_ready), (expq.size() == 0) ? 1 : 0);
        check("o_valid", int'(o_valid), (expq.size() != 0) ? 1 : 0);
        if (expq.size() != 0) begin
            check("o_mant", int'(o_mant), expq[0].mant);
            check("o_shift", int'(o_shift), expq[0].shift);
            check("o_last", int'(o_last), expq[0].last);
            check("o_max_exp", int'(o_max_exp), expq[0].maxe);
        end
        acc = v && (expq.size() == 0) && !clr;
        xf  = (expq.size() != 0) && rdy && !clr;
        @(posedge clk);
        #1;
        if (clr) begin
            grp_m.delete();
            grp_e.delete();
            expq.delete();
        end else if (acc) begin
            grp_m.push_back(int'(m));
            grp_e.push_back(int'(e));
            if (grp_e.size() == GROUP) build_group();
        end else if (xf) begin
            void'(expq.pop_front());
        end
    endtask

    bit pat[11] = '{1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1};

    initial begin
        int                   em;
        int                   es;
        logic signed [MW-1:0] rm;
        logic [EW-1:0]        re;
        bit                   rv;
        bit                   rr;
        bit                   rc;

        n_tests = 0;
        n_fail  = 0;

        tbl[0]  = '{10, 3, 4, 0, 7};
        tbl[1]  = '{-20, 7, 0, 0, 7};
        tbl[2]  = '{30, 5, 2, 0, 7};
        tbl[3]  = '{-40, 7, 0, 0, 7};
        tbl[4]  = '{50, 0, 7, 0, 7};
        tbl[5]  = '{-60, 1, 6, 0, 7};
        tbl[6]  = '{70, 6, 1, 0, 7};
        tbl[7]  = '{-511, 2, 5, 0, 7};
        tbl[8]  = '{-512, 20, 7, 1, 31};
        tbl[9]  = '{100, 31, 0, 0, 31};
        tbl[10] = '{-1, 0, 7, 1, 31};
        tbl[11] = '{5, 31, 0, 0, 31};
        tbl[12] = '{7, 28, 3, 0, 31};
        tbl[13] = '{-300, 24, 7, 0, 31};
        tbl[14] = '{511, 23, 7, 1, 31};
        tbl[15] = '{1, 10, 7, 1, 31};

        rst_n   = 1'b0;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_mant  = '0;
        i_exp   = '0;
        #2;
        check("rst_o_ready", int'(o_ready), 1);
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_mant", int'(o_mant), 0);
        check("rst_o_shift", int'(o_shift), 0);
        check("rst_o_max_exp", int'(o_max_exp), 0);
        check("rst_o_last", int'(o_last), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table groups: explicit expected shifts, last flag and flush behaviour.
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < GROUP; i++) begin
                step(1'b1, MW'(tbl[g*GROUP+i].mant), EW'(tbl[g*GROUP+i].exp), 1'b1, 1'b0);
            end
            check("first_valid_latency", int'(o_valid), 1);
            for (int i = 0; i < GROUP; i++) begin
                int k;
                k = g * GROUP + i;
`ifdef ALIGN_FLUSH_EN
                em = (tbl[k].flushed != 0) ? 0 : tbl[k].mant;
                es = (tbl[k].flushed != 0) ? 0 : tbl[k].shift;
`else
                em = tbl[k].mant;
                es = tbl[k].shift;
`endif
                check("tbl_mant", int'(o_mant), em);
                check("tbl_shift", int'(o_shift), es);
                check("tbl_last", int'(o_last), (i == GROUP - 1) ? 1 : 0);
                check("tbl_max_exp", int'(o_max_exp), tbl[k].maxe);
                step(1'b0, '0, '0, 1'b1, 1'b0);
            end
            check("drain_done_valid", int'(o_valid), 0);
        end

        // Downstream stalls during DRAIN.
        for (int i = 0; i < GROUP; i++) step(1'b1, MW'($urandom), EW'($urandom_range(0, 31)), 1'b0, 1'b0);
        for (int k = 0; k < 11; k++) step(1'b0, '0, '0, pat[k], 1'b0);

        // Abort a partial group, then an all-equal-exponent group.
        for (int i = 0; i < 5; i++) step(1'b1, MW'($urandom), 5'd30, 1'b1, 1'b0);
        step(1'b1, MW'($urandom), 5'd31, 1'b1, 1'b1);
        check("clear_no_output", int'(o_valid), 0);
        for (int i = 0; i < GROUP; i++) step(1'b1, MW'($urandom), 5'd4, 1'b1, 1'b0);
        for (int i = 0; i < GROUP; i++) begin
            check("eq_max_exp", int'(o_max_exp), 4);
            check("eq_shift", int'(o_shift), 0);
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end

        // Asynchronous reset mid-DRAIN.
        for (int i = 0; i < GROUP; i++) step(1'b1, MW'($urandom), EW'($urandom_range(0, 31)), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(o_valid), 0);
        check("async_rst_ready", int'(o_ready), 1);
        check("async_rst_mant", int'(o_mant), 0);
        check("async_rst_max_exp", int'(o_max_exp), 0);
        #1;
        rst_n = 1'b1;
        grp_m.delete();
        grp_e.delete();
        expq.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < GROUP; i++) step(1'b1, MW'($urandom), EW'($urandom_range(0, 31)), 1'b1, 1'b0);
        for (int i = 0; i < GROUP; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

        // i_valid held high through DRAIN must not be accepted until FILL resumes.
        for (int i = 0; i < 3 * GROUP; i++) begin
            step(1'b1, MW'($urandom), EW'($urandom_range(0, 31)), (i % 3) != 0, 1'b0);
        end
        for (int i = 0; i < 2 * GROUP; i++) step(1'b1, MW'($urandom), EW'($urandom_range(0, 31)), 1'b1, 1'b0);

        // Randomized traffic with occasional clears.
        for (int n = 0; n < 600; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 49) == 0);
            rm = MW'($urandom);
            re = ($urandom_range(0, 1) != 0) ? EW'($urandom_range(20, 27)) : EW'($urandom_range(0, 31));
            step(rv, rm, re, rr, rc);
        end
        for (int n = 0; n < 2 * GROUP; n++) step(1'b0, '0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/group_align_ctrl.md
Name: group_align_ctrl

Overview:
Alignment front-end for the accumulation path. Collects a fixed-size group of (mantissa, exponent) elements and finds the group's maximum exponent. Then replays each element with shift = max_exp - exp. Output feeds the per-lane arithmetic right shifter directly: o_mant drives its data input and o_shift drives its shift input.

Parameters:
MANT_WIDTH, 10, signed mantissa width; equals the shifter's data input width.
EXP_WIDTH, 5, unsigned exponent width.
SHIFT_WIDTH, 3, shift-value width; equals the shifter's shift input width.
GROUP, 8, elements per group; must be >= 2.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst_n  input  1  reset, asynchronous, active-low.
i_clear  input  1  synchronous abort; discards the current group.
i_valid  input  1  upstream element valid.
o_ready  output  1  block can accept an element.
i_mant  input  MANT_WIDTH  signed mantissa.
i_exp  input  EXP_WIDTH  unsigned exponent.
o_valid  output  1  aligned element valid.
i_ready  input  1  downstream accepts the element.
o_mant  output  MANT_WIDTH  mantissa for the shifter.
o_shift  output  SHIFT_WIDTH  right-shift amount for the shifter.
o_max_exp  output  EXP_WIDTH  group maximum exponent; stable for the whole DRAIN phase.
o_last  output  1  marks the final element of a group.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=FILL, counters=0, max register=0.
  - o_ready=1, o_valid=0, o_mant=0, o_shift=0, o_max_exp=0, o_last=0.
- Handshakes: a transfer occurs when valid and ready are both 1 on a rising edge. The handshake is registered and has no combinational path from i_ready to o_ready.
- FILL state:
  - o_ready=1, o_valid=0.
  - Each accepted element is written to buffer[wr_cnt]; wr_cnt increments.
  - max_exp is updated to the larger of max_exp and i_exp. On the first element of a group, max_exp is loaded with i_exp, not compared against the old value.
  - When element GROUP-1 is accepted: wr_cnt->0, state->DRAIN, and o_max_exp latches the final max (including that element) in the same edge.
- DRAIN state:
  - o_ready=0, o_valid=1.
  - Output index rd_cnt; o_mant = buffer[rd_cnt].
  - d = o_max_exp - exp[rd_cnt], always >= 0, computed in EXP_WIDTH bits.
  - o_shift = d if d <= 2^SHIFT_WIDTH-1; otherwise saturate to 2^SHIFT_WIDTH-1 (see Optional Feature).
  - o_last = (rd_cnt == GROUP-1).
  - On transfer, rd_cnt increments. After the last transfer, rd_cnt->0 and state->FILL.
- Latency: the first output is valid the cycle after the last input is accepted. With downstream always ready, throughput is GROUP in + GROUP out, i.e. 2*GROUP cycles per group.
- Outputs hold steady while o_valid=1 and i_ready=0.
- i_clear has priority over everything; same-cycle handshakes are ignored. Next edge: state=FILL, counters=0, o_valid=0. Buffer contents need not be cleared.
- An async reset asserted mid-group discards the group, with the same end state as reset.
- Equal exponents across the group give o_shift=0 for every element.
- Buffer storage is plain flops with no reset; only control registers and outputs are reset.

Optional Feature:
Macro ALIGN_FLUSH_EN.
- Defined: when d > 2^SHIFT_WIDTH-1, o_mant=0 and o_shift=0. The element contributes nothing downstream.
- Undefined: o_mant is passed unchanged and o_shift saturates to 2^SHIFT_WIDTH-1.
- Handshake and timing are identical in both builds.

Decomposition:
- Package npu_align_pkg holds:
  - state enum (FILL, DRAIN);
  - localparam function clog2-based counter width for GROUP;
  - the saturating shift-limit constant derived from SHIFT_WIDTH.
- One sub-module, align_shift_calc: combinational. Takes max_exp and exp, produces d, applies saturation or flush, and outputs the shift and a flush flag.
- The top level holds the FSM, counters and buffer.

Test Plan:
- GROUP=8, exps {3,7,5,7,0,1,6,2}, i_ready=1 -> o_max_exp=7; o_shift={4,0,2,0,7,6,1,5}; o_last only on the 8th output; first o_valid one cycle after the 8th accept.
- Mantissa -512 with exp 20 in a group whose max is 31 (d=11) -> undefined build: o_mant=-512, o_shift=7; ALIGN_FLUSH_EN build: o_mant=0, o_shift=0.
- Downstream i_ready toggles 1,0,0,1 during DRAIN -> o_mant/o_shift/o_last stable while stalled; no element lost or duplicated; o_ready=0 throughout.
- i_clear after 5 accepts, then a full new group of all exp=4 -> no output from the partial group; new group yields o_max_exp=4 and all o_shift=0.
- i_rst_n dropped asynchronously mid-DRAIN (between edges) -> o_valid=0 and o_ready=1 immediately; next group processes normally.
- i_valid held 1 while in DRAIN -> no accept (o_ready=0); the input sample is taken only after return to FILL.
